// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide unit controller: owns HI/LO, sequences multi-cycle
// mult/div operations and requests D-stage stalls while the unit is occupied.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        d_is_mdu,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] mdu_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic          op_signed;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic        div_zero;
  logic [63:0] prod_mag;
  logic [63:0] prod;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        start_long;

  // Sign-magnitude arithmetic on the latched operands; this keeps the
  // 0x80000000 / -1 corner well defined (quotient wraps back to 0x80000000).
  always_comb begin
    a_neg    = op_signed & op_a[31];
    b_neg    = op_signed & op_b[31];
    a_mag    = a_neg ? (-op_a) : op_a;
    b_mag    = b_neg ? (-op_b) : op_b;
    div_zero = (op_b == 32'd0);
    b_safe   = div_zero ? 32'd1 : b_mag;
    prod_mag = {32'd0, a_mag} * {32'd0, b_mag};
    prod     = (a_neg ^ b_neg) ? (-prod_mag) : prod_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
    rem      = a_neg ? (-r_mag) : r_mag;
  end

  // Stall/read-port decode; stall is forced low while reset is held.
  always_comb begin
    start_long = start & (mdu_op >= 4'd1) & (mdu_op <= 4'd4);
    busy       = (state != IDLE);
    stall      = ~reset & d_is_mdu & (busy | start_long);
    hi_out     = hi;
    lo_out     = lo;
    case (mdu_op)
      4'd5:    mdu_out = hi;
      4'd6:    mdu_out = lo;
      default: mdu_out = 32'd0;
    endcase
  end

  // Main FSM: accepts new work only in IDLE, counts down, commits HI/LO on 1->0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      op_signed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdu_op)
              4'd1, 4'd2: begin
                op_a      <= rs_data;
                op_b      <= rt_data;
                op_signed <= (mdu_op == 4'd1);
                cnt       <= MULT_LOAD;
                state     <= MULT;
              end
              4'd3, 4'd4: begin
                op_a      <= rs_data;
                op_b      <= rt_data;
                op_signed <= (mdu_op == 4'd3);
                cnt       <= DIV_LOAD;
                state     <= DIV;
              end
              4'd7:    hi <= rs_data;
              4'd8:    lo <= rs_data;
              default: ;
            endcase
          end
        end
        MULT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            state <= IDLE;
          end
        end
        DIV: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            if (!div_zero) begin
              hi <= rem;
              lo <= quot;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: directed operations feed a scoreboard of
// expected HI/LO/busy-length, drained by a monitor on each busy falling edge.
module tb_e_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        d_is_mdu;
  logic        busy;
  logic        stall;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic [31:0] mdu_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  logic prev_busy;
  int   busy_cnt;

  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdu_op   (mdu_op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .d_is_mdu (d_is_mdu),
    .busy     (busy),
    .stall    (stall),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .mdu_out  (mdu_out)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop if something wedges the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [31:0] hi, input logic [31:0] lo, input int cycles);
    exp_t e;
    e.hi     = hi;
    e.lo     = lo;
    e.cycles = cycles;
    sb.push_back(e);
  endtask

  // One-cycle start pulse captured at the next rising edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    start   = 1'b1;
    mdu_op  = op;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = 4'd0;
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle timeout busy=%0b required=0", busy);
    end
  endtask

  // Monitor: counts busy cycles and checks HI/LO when an operation completes.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_completion hi=0x%08h lo=0x%08h required=none", hi_out, lo_out);
        end else begin
          e = sb.pop_front();
          checkOutput("done_hi", hi_out, e.hi);
          checkOutput("done_lo", lo_out, e.lo);
          checkOutput("busy_cycles", 32'(busy_cnt), 32'(e.cycles));
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    prev_busy = 1'b0;
    busy_cnt  = 0;
    reset     = 1'b1;
    start     = 1'b1;
    mdu_op    = 4'd1;
    rs_data   = 32'h1234_5678;
    rt_data   = 32'h9;
    d_is_mdu  = 1'b1;

    // Reset state with provocative inputs applied
    #12;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    checkOutput("rst_hi", hi_out, 32'd0);
    checkOutput("rst_lo", lo_out, 32'd0);
    start    = 1'b0;
    mdu_op   = 4'd0;
    d_is_mdu = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;

    // Signed and unsigned multiply
    pushExp(32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    applyStimulus(4'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    waitIdle();
    pushExp(32'h0000_0002, 32'hFFFF_FFFA, 5);
    applyStimulus(4'd2, 32'hFFFF_FFFE, 32'h0000_0003);
    waitIdle();

    // Signed divide -7 / 2
    pushExp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    applyStimulus(4'd3, 32'hFFFF_FFF9, 32'h0000_0002);
    waitIdle();

    // mthi/mtlo are single-cycle writes
    applyStimulus(4'd7, 32'h0000_0011, 32'h0);
    checkOutput("mthi_hi", hi_out, 32'h0000_0011);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    applyStimulus(4'd8, 32'h0000_0022, 32'h0);
    checkOutput("mtlo_lo", lo_out, 32'h0000_0022);

    // Divide by zero keeps HI/LO but still takes the full time
    pushExp(32'h0000_0011, 32'h0000_0022, 10);
    applyStimulus(4'd4, 32'h0000_0064, 32'h0);
    waitIdle();

    // Unsigned 100 / 7, overflow corner, signed 7 / -2
    pushExp(32'h0000_0002, 32'h0000_000E, 10);
    applyStimulus(4'd4, 32'h0000_0064, 32'h0000_0007);
    waitIdle();
    pushExp(32'h0000_0000, 32'h8000_0000, 10);
    applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle();
    pushExp(32'h0000_0001, 32'hFFFF_FFFD, 10);
    applyStimulus(4'd3, 32'h0000_0007, 32'hFFFF_FFFE);
    waitIdle();

    // Idle stall decode and read port
    @(posedge clk);
    #1;
    start    = 1'b1;
    mdu_op   = 4'd3;
    d_is_mdu = 1'b1;
    #1 checkOutput("idle_stall_div", {31'd0, stall}, 32'd1);
    mdu_op = 4'd5;
    #1 checkOutput("idle_stall_mfhi", {31'd0, stall}, 32'd0);
    checkOutput("idle_mfhi", mdu_out, 32'h0000_0001);
    mdu_op   = 4'd3;
    d_is_mdu = 1'b0;
    #1 checkOutput("idle_stall_nod", {31'd0, stall}, 32'd0);
    start  = 1'b0;
    mdu_op = 4'd0;

    // Stall during div, ignored starts, operand changes while busy
    pushExp(32'h0000_0002, 32'hFFFF_FFF2, 10);
    applyStimulus(4'd3, 32'h0000_0064, 32'hFFFF_FFF9);
    d_is_mdu = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("busy_stall_%0d", i), {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      case (i)
        2: begin
          start = 1'b1; mdu_op = 4'd1; rs_data = 32'h5; rt_data = 32'h9;
        end
        3: begin
          start = 1'b0; mdu_op = 4'd0;
        end
        5: begin
          rs_data = 32'hDEAD_BEEF; rt_data = 32'h0;
        end
        8: begin
          start = 1'b1; mdu_op = 4'd3; rs_data = 32'h1; rt_data = 32'h1;
        end
        default: ;
      endcase
    end
    start    = 1'b0;
    mdu_op   = 4'd0;
    d_is_mdu = 1'b0;
    checkOutput("completion_start_ignored", {31'd0, busy}, 32'd0);
    mdu_op = 4'd5;
    #1 checkOutput("mfhi_after_div", mdu_out, 32'h0000_0002);
    mdu_op = 4'd6;
    #1 checkOutput("mflo_after_div", mdu_out, 32'hFFFF_FFF2);
    mdu_op = 4'd0;
    @(negedge clk);

    // Reset mid-mult aborts without touching HI/LO, then mtlo works
    applyStimulus(4'd1, 32'h3, 32'h4);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_hi", hi_out, 32'd0);
    checkOutput("abort_lo", lo_out, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    applyStimulus(4'd8, 32'h0000_1234, 32'h0);
    checkOutput("post_rst_lo", lo_out, 32'h0000_1234);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu_ctrl.md
E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 SHALL have port mdu_op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-007 SHALL have port rs_data  input  32  operand A / mthi-mtlo source.
REQ-008 SHALL have port rt_data  input  32  operand B.
REQ-009 SHALL have port d_is_mdu  input  1  D-stage instruction is any of ops 1-8.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-011 SHALL have port stall  output  1  D-stage stall request.
REQ-012 SHALL have port hi_out  output  32  current HI register.
REQ-013 SHALL have port lo_out  output  32  current LO register.
REQ-014 SHALL have port mdu_out  output  32  HI when mdu_op=5, LO when mdu_op=6, else 0.

Function
REQ-015 SHALL implement an FSM with states IDLE, MULT, DIV, plus a cycle counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-016 In IDLE, on start with op 1/2 at edge T, SHALL latch operands, load the counter with MULT_CYCLES, and enter MULT; ops 3/4 SHALL load DIV_CYCLES and enter DIV.
REQ-017 busy SHALL equal (state != IDLE), so it is high for exactly N cycles following the start edge.
REQ-018 SHALL decrement the counter once per cycle in MULT/DIV; at the edge where it goes 1->0 SHALL write HI/LO and return to IDLE, with busy low in the next cycle.
REQ-019 mult SHALL produce a signed 64-bit product and multu an unsigned one, with HI=[63:32] and LO=[31:0].
REQ-020 div/divu SHALL set LO=quotient truncated toward zero and HI=remainder with the sign of the dividend; divu SHALL treat operands as unsigned.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-022 A divisor of 0 SHALL still occupy DIV_CYCLES with busy high, and SHALL leave HI/LO unchanged at completion.
REQ-023 mthi/mtlo with start in IDLE SHALL write rs_data into HI/LO at that edge; single cycle, busy stays 0.
REQ-024 mfhi/mflo SHALL be combinational reads of the current HI/LO; no state change.
REQ-025 start while busy=1 SHALL be ignored: no operand latch, no HI/LO write, no counter reload.
REQ-026 stall SHALL equal d_is_mdu & (busy | (start & mdu_op in 1..4)).
REQ-027 In a completion cycle (counter=1), a start SHALL be ignored per REQ-025; the new operation SHALL be accepted only in the following IDLE cycle.
REQ-028 Operands SHALL be held in internal registers for the whole operation; changes on rs_data/rt_data during busy SHALL NOT affect the result.

Reset
REQ-029 reset high SHALL asynchronously force state=IDLE, counter=0, HI=0, LO=0, latched operands=0, busy=0, and stall=0 (for any inputs).
REQ-030 reset asserted mid-operation SHALL abort the operation; no partial HI/LO write SHALL occur, and the first edge after reset deassertion SHALL behave as IDLE.

Verification
REQ-031 mult rs=0xFFFFFFFE, rt=0x00000003 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 multu with the same operands -> after 5 cycles HI=0x00000002, LO=0xFFFFFFFA.
REQ-033 div rs=0xFFFFFFF9 (-7), rt=2 -> busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-034 divu rt=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> busy for 10 cycles; HI/LO remain 0x11/0x22.
REQ-035 During a div, with d_is_mdu=1 -> stall=1 every busy cycle; a second start with rs=5 is ignored; mfhi after completion returns the first result.
REQ-036 reset asserted on cycle 3 of a mult -> busy=0 and HI=LO=0 immediately; a mtlo 0x1234 issued afterwards sets lo_out=0x1234 on the next edge.
